// File: rtl/mem_wb_writeback.sv
// MEM/WB pipeline register with load alignment/extension and writeback select.
// Drives the register-file write port and doubles as the WB forwarding source.
module mem_wb_writeback #(
  parameter int width     = 32,
  parameter int AddrWidth = 5,
  parameter int CntWidth  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 MEM_valid,
  input  logic                 MEM_RegWrite,
  input  logic                 MEM_MemtoReg,
  input  logic                 MEM_Link,
  input  logic [2:0]           MEM_LoadType,
  input  logic [AddrWidth-1:0] MEM_Write_register,
  input  logic [width-1:0]     MEM_ALU_result,
  input  logic [width-1:0]     MEM_Mem_data,
  input  logic [width-1:0]     MEM_PC_plus8,
  output logic                 RegWrite,
  output logic [AddrWidth-1:0] Write_register,
  output logic [width-1:0]     Write_data,
  output logic                 WB_valid,
  output logic                 Misalign,
  output logic [CntWidth-1:0]  Retire_count
);

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LB  = 3'b001,
    LT_LBU = 3'b010,
    LT_LH  = 3'b011,
    LT_LHU = 3'b100
  } load_type_e;

  logic [1:0]           off;
  logic [7:0]           ld_byte;
  logic [15:0]          ld_half;
  logic [width-1:0]     load_val;
  logic                 align_bad;
  logic                 misalign_d;
  logic                 reg_write_d;
  logic [width-1:0]     write_data_d;

  logic                 reg_write_q;
  logic [AddrWidth-1:0] write_register_q;
  logic [width-1:0]     write_data_q;
  logic                 wb_valid_q;
  logic                 misalign_q;
  logic [CntWidth-1:0]  retire_count_q;

  assign off     = MEM_ALU_result[1:0];
  assign ld_byte = MEM_Mem_data[{off, 3'b000} +: 8];
  assign ld_half = off[1] ? MEM_Mem_data[31:16] : MEM_Mem_data[15:0];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    load_val  = MEM_Mem_data;
    align_bad = (off != 2'b00);
    case (MEM_LoadType)
      LT_LB: begin
        load_val  = {{(width-8){ld_byte[7]}}, ld_byte};
        align_bad = 1'b0;
      end
      LT_LBU: begin
        load_val  = {{(width-8){1'b0}}, ld_byte};
        align_bad = 1'b0;
      end
      LT_LH: begin
        load_val  = {{(width-16){ld_half[15]}}, ld_half};
        align_bad = off[0];
      end
      LT_LHU: begin
        load_val  = {{(width-16){1'b0}}, ld_half};
        align_bad = off[0];
      end
      default: ;
    endcase
  end

  // Link outranks MemtoReg so JAL-style writes never pick up stale load data.
  always_comb begin
    write_data_d = MEM_ALU_result;
    if (MEM_Link)          write_data_d = MEM_PC_plus8;
    else if (MEM_MemtoReg) write_data_d = load_val;
  end

  assign misalign_d  = MEM_valid & MEM_MemtoReg & ~MEM_Link & align_bad;
  assign reg_write_d = MEM_valid & MEM_RegWrite & (MEM_Write_register != '0) & ~misalign_d;

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      wb_valid_q       <= 1'b0;
      misalign_q       <= 1'b0;
      retire_count_q   <= '0;
    end else if (flush) begin
      reg_write_q      <= 1'b0;
      write_register_q <= '0;
      write_data_q     <= '0;
      wb_valid_q       <= 1'b0;
      misalign_q       <= 1'b0;
    end else if (!stall) begin
      reg_write_q      <= reg_write_d;
      write_register_q <= MEM_Write_register;
      write_data_q     <= write_data_d;
      wb_valid_q       <= MEM_valid;
      misalign_q       <= misalign_d;
      // Suppressed writes still retire, so the count follows MEM_valid alone.
      if (MEM_valid) retire_count_q <= retire_count_q + CntWidth'(1);
    end
  end

  assign RegWrite       = reg_write_q;
  assign Write_register = write_register_q;
  assign Write_data     = write_data_q;
  assign WB_valid       = wb_valid_q;
  assign Misalign       = misalign_q;
  assign Retire_count   = retire_count_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// Randomised and directed bench for mem_wb_writeback against a behavioural model.
// The counter is narrowed to 8 bits so the all-ones wrap is reachable quickly.
module tb_mem_wb_writeback;

  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          reset, stall, flush;
  logic          MEM_valid, MEM_RegWrite, MEM_MemtoReg, MEM_Link;
  logic [2:0]    MEM_LoadType;
  logic [4:0]    MEM_Write_register;
  logic [31:0]   MEM_ALU_result, MEM_Mem_data, MEM_PC_plus8;
  logic          RegWrite, WB_valid, Misalign;
  logic [4:0]    Write_register;
  logic [31:0]   Write_data;
  logic [CW-1:0] Retire_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of what the outputs should be after the most recent edge.
  bit          m_valid, m_rw, m_mis;
  logic [4:0]  m_wreg;
  logic [31:0] m_wdata;
  int          m_cnt;

  mem_wb_writeback #(.width(32), .AddrWidth(5), .CntWidth(CW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .MEM_valid(MEM_valid), .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_Link(MEM_Link), .MEM_LoadType(MEM_LoadType), .MEM_Write_register(MEM_Write_register),
    .MEM_ALU_result(MEM_ALU_result), .MEM_Mem_data(MEM_Mem_data), .MEM_PC_plus8(MEM_PC_plus8),
    .RegWrite(RegWrite), .Write_register(Write_register), .Write_data(Write_data),
    .WB_valid(WB_valid), .Misalign(Misalign), .Retire_count(Retire_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Load value from the little-endian extraction rules, using plain arithmetic.
  function automatic logic [31:0] ref_load(input logic [2:0] lt, input logic [31:0] d,
                                           input int off, output bit bad);
    int unsigned b, h;
    b   = (d >> (8 * off)) & 32'hFF;
    h   = (d >> (16 * (off / 2))) & 32'hFFFF;
    bad = 1'b0;
    case (lt)
      3'd1: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd2: return b;
      3'd3: begin bad = (off % 2) != 0; return (h >= 32768) ? h + 32'hFFFF_0000 : h; end
      3'd4: begin bad = (off % 2) != 0; return h; end
      default: begin bad = (off != 0); return d; end
    endcase
  endfunction

  task automatic set_in(input bit v, input bit rw, input bit mtr, input bit lnk,
                        input logic [2:0] lt, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] mem, input logic [31:0] pc);
    MEM_valid = v; MEM_RegWrite = rw; MEM_MemtoReg = mtr; MEM_Link = lnk;
    MEM_LoadType = lt; MEM_Write_register = rd;
    MEM_ALU_result = alu; MEM_Mem_data = mem; MEM_PC_plus8 = pc;
  endtask

  // Advance the model from the current inputs, clock once, compare every output.
  task automatic cycle();
    bit          bad, mis;
    logic [31:0] lv, wd;
    lv  = ref_load(MEM_LoadType, MEM_Mem_data, int'(MEM_ALU_result % 4), bad);
    mis = MEM_valid && MEM_MemtoReg && !MEM_Link && bad;
    wd  = MEM_Link ? MEM_PC_plus8 : (MEM_MemtoReg ? lv : MEM_ALU_result);
    if (reset) begin
      m_valid = 0; m_rw = 0; m_mis = 0; m_wreg = 0; m_wdata = 0; m_cnt = 0;
    end else if (flush) begin
      m_valid = 0; m_rw = 0; m_mis = 0; m_wreg = 0; m_wdata = 0;
    end else if (!stall) begin
      m_valid = MEM_valid;
      m_mis   = mis;
      m_rw    = MEM_valid && MEM_RegWrite && (MEM_Write_register != 0) && !mis;
      m_wreg  = MEM_Write_register;
      m_wdata = wd;
      if (MEM_valid) m_cnt = (m_cnt + 1) % (1 << CW);
    end
    @(posedge clk);
    #1;
    check("wb_valid", 32'(WB_valid), 32'(m_valid));
    check("regwrite", 32'(RegWrite), 32'(m_rw));
    check("misalign", 32'(Misalign), 32'(m_mis));
    check("wreg",     32'(Write_register), 32'(m_wreg));
    check("wdata",    Write_data, m_wdata);
    check("retire",   32'(Retire_count), 32'(m_cnt));
  endtask

  typedef struct { logic [2:0] lt; logic [31:0] alu; logic [31:0] exp; string tag; } ld_vec_t;
  ld_vec_t ld_tab[5];

  initial begin
    ld_tab[0] = '{3'd1, 32'h0000_2003, 32'hFFFF_FF80, "lb_off3"};
    ld_tab[1] = '{3'd2, 32'h0000_2003, 32'h0000_0080, "lbu_off3"};
    ld_tab[2] = '{3'd3, 32'h0000_2002, 32'hFFFF_80FF, "lh_off2"};
    ld_tab[3] = '{3'd4, 32'h0000_2000, 32'h0000_7F01, "lhu_off0"};
    ld_tab[4] = '{3'd0, 32'h0000_2000, 32'h80FF_7F01, "lw_off0"};

    reset = 1; stall = 0; flush = 0;
    set_in(0, 0, 0, 0, 3'd0, 5'd0, 32'h0, 32'h0, 32'h0);
    cycle();
    reset = 0;

    // Plain ALU write.
    set_in(1, 1, 0, 0, 3'd0, 5'd8, 32'h1234_5678, 32'h0, 32'h0);
    cycle();
    check("alu_wdata", Write_data, 32'h1234_5678);
    check("alu_count", 32'(Retire_count), 32'd1);

    // Load extension table.
    foreach (ld_tab[i]) begin
      set_in(1, 1, 1, 0, ld_tab[i].lt, 5'd9, ld_tab[i].alu, 32'h80FF_7F01, 32'h0);
      cycle();
      check(ld_tab[i].tag, Write_data, ld_tab[i].exp);
      check({ld_tab[i].tag, "_we"}, 32'(RegWrite), 32'd1);
    end

    // Misaligned loads.
    set_in(1, 1, 1, 0, 3'd3, 5'd9, 32'h0000_2001, 32'h80FF_7F01, 32'h0);
    cycle();
    check("lh_mis_flag", 32'(Misalign), 32'd1);
    check("lh_mis_we", 32'(RegWrite), 32'd0);
    check("lh_mis_count", 32'(Retire_count), 32'd7);
    set_in(1, 1, 1, 0, 3'd0, 5'd9, 32'h0000_2002, 32'h80FF_7F01, 32'h0);
    cycle();
    check("lw_mis_flag", 32'(Misalign), 32'd1);
    check("lw_mis_we", 32'(RegWrite), 32'd0);

    // r0 destination and link priority.
    set_in(1, 1, 0, 0, 3'd0, 5'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
    cycle();
    check("r0_we", 32'(RegWrite), 32'd0);
    check("r0_count", 32'(Retire_count), 32'd9);
    set_in(1, 1, 1, 1, 3'd0, 5'd31, 32'h0000_2002, 32'h80FF_7F01, 32'h0000_0408);
    cycle();
    check("link_wdata", Write_data, 32'h0000_0408);
    check("link_mis", 32'(Misalign), 32'd0);

    // Stall holds everything, including the count.
    set_in(1, 1, 0, 0, 3'd0, 5'd5, 32'h0000_000A, 32'h0, 32'h0);
    cycle();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      set_in(1, 1, 0, 0, 3'd0, 5'(i + 12), $urandom, $urandom, $urandom);
      cycle();
      check("stall_wreg", 32'(Write_register), 32'd5);
      check("stall_wdata", Write_data, 32'h0000_000A);
      check("stall_count", 32'(Retire_count), 32'd11);
    end
    flush = 1;
    cycle();
    check("flush_valid", 32'(WB_valid), 32'd0);
    check("flush_we", 32'(RegWrite), 32'd0);
    stall = 0; flush = 0;

    // Reset mid-stream.
    set_in(1, 1, 0, 0, 3'd0, 5'd3, 32'h0000_0033, 32'h0, 32'h0);
    cycle();
    reset = 1;
    cycle();
    check("rst_we", 32'(RegWrite), 32'd0);
    check("rst_count", 32'(Retire_count), 32'd0);
    reset = 0;

    // Count up to all-ones, then wrap.
    for (int i = 0; i < (1 << CW) - 1; i++) begin
      set_in(1, $urandom_range(1), 0, 0, 3'd0, 5'($urandom), $urandom, 32'h0, 32'h0);
      cycle();
    end
    check("cnt_allones", 32'(Retire_count), 32'((1 << CW) - 1));
    set_in(1, 1, 0, 0, 3'd0, 5'd4, 32'h1, 32'h0, 32'h0);
    cycle();
    check("cnt_wrap", 32'(Retire_count), 32'd0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(49) == 0);
      flush = ($urandom_range(9) == 0);
      stall = ($urandom_range(4) == 0);
      set_in($urandom_range(3) != 0, $urandom_range(1), $urandom_range(1),
             $urandom_range(7) == 0, 3'($urandom_range(7)), 5'($urandom_range(31)),
             $urandom, $urandom, $urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_writeback.md
Name: mem_wb_writeback

Overview:
- MEM/WB pipeline register and writeback-select stage of the 5-stage MIPS pipeline.
- Captures the MEM-stage result each cycle, then aligns and sign/zero-extends load data.
- Selects link, load or ALU data and drives the register file write port: RegWrite, Write_register and Write_data.
- Also provides a retired-instruction counter and a misaligned-load flag for debug.

Parameters:
- width, 32, datapath width.
- AddrWidth, 5, register address width.
- CntWidth, 32, width of the retire counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous reset, active-high.
- stall  in  1  hold the stage contents.
- flush  in  1  load a bubble instead of MEM data.
- MEM_valid  in  1  MEM stage holds a real instruction.
- MEM_RegWrite  in  1  instruction writes a register.
- MEM_MemtoReg  in  1  write data comes from memory.
- MEM_Link  in  1  write PC+8 (JAL/JALR/BGEZAL).
- MEM_LoadType  in  3  000 LW, 001 LB, 010 LBU, 011 LH, 100 LHU; any other code is treated as LW.
- MEM_Write_register  in  AddrWidth  destination register.
- MEM_ALU_result  in  width  ALU result; bits [1:0] are the load byte offset.
- MEM_Mem_data  in  width  raw word read from data memory.
- MEM_PC_plus8  in  width  link value.
- RegWrite  out  1  register-file write enable.
- Write_register  out  AddrWidth  register-file write address.
- Write_data  out  width  register-file write data.
- WB_valid  out  1  stage holds a real instruction.
- Misalign  out  1  held instruction is a misaligned load.
- Retire_count  out  CntWidth  number of valid instructions captured.

Behaviour:
- Single clock domain. Every output is a flop; no output is combinational from the inputs.
- Reset is synchronous and active-high. On reset, every output is 0, including Retire_count.
- Reset has priority over flush, and flush has priority over stall.
- Reset arriving mid-operation discards the held instruction at that edge.
- Capture edge (no reset, no flush, no stall):
  - WB_valid <= MEM_valid.
  - Write_register <= MEM_Write_register.
  - Write_data <= selected data.
  - Misalign <= computed misalign condition.
  - RegWrite <= MEM_valid & MEM_RegWrite & (MEM_Write_register != 0) & ~misalign.
- Flush edge:
  - WB_valid, RegWrite and Misalign are set to 0.
  - Write_register and Write_data are set to 0.
  - Retire_count is unchanged.
- Stall edge:
  - All outputs hold, including RegWrite.
  - The repeated identical write to the register file is permitted because it is idempotent.
  - Retire_count does not increment.
- Retire_count increments by 1 on every capture edge with MEM_valid=1.
  - It counts suppressed writes (r0 destination, misaligned load) too.
  - It wraps from all-ones to 0.
- Data select priority:
  - MEM_Link selects MEM_PC_plus8.
  - Otherwise MEM_MemtoReg selects the aligned load value.
  - Otherwise MEM_ALU_result.
- Load alignment is little-endian with offset off = MEM_ALU_result[1:0]:
  - LB/LBU take byte off (off=0 is bits [7:0]), then sign- or zero-extend.
  - LH/LHU take halfword off[1]; they require off[0]=0, then sign- or zero-extend.
  - LW requires off=0.
- Misalign condition:
  - Asserted only when MEM_valid & MEM_MemtoReg & ~MEM_Link and the alignment rule is violated.
  - When asserted, Write_data still captures the extracted value, but RegWrite is 0.
- Latency:
  - MEM inputs sampled at edge N appear on the outputs after edge N.
  - The register file commits them at edge N+1.
  - The outputs double as the WB forwarding source for the hazard/forward unit.

Test Plan:
- ALU write: MEM_valid=1, RegWrite=1, reg=8, ALU_result=0x12345678, no stall -> next cycle RegWrite=1, Write_register=8, Write_data=0x12345678, Retire_count=1.
- Load extension: Mem_data=0x80FF7F01.
  - LB off=3 -> 0xFFFFFF80; LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF; LHU off=0 -> 0x00007F01.
  - LW off=0 -> 0x80FF7F01.
- Misaligned: LH off=1 -> Misalign=1, RegWrite=0, Retire_count increments. LW off=2 -> Misalign=1, RegWrite=0.
- r0 and link:
  - reg=0, RegWrite=1 -> RegWrite out 0, count increments.
  - Link=1 with MemtoReg=1, PC_plus8=0x00000408 -> Write_data=0x00000408.
- Stall/flush:
  - Capture reg=5/0xA, then stall 3 cycles with new inputs -> outputs hold 5/0xA and count is unchanged.
  - Flush together with stall -> WB_valid=0, RegWrite=0.
- Reset mid-stream: reset=1 while RegWrite=1 -> after the edge all outputs are 0 and Retire_count=0. Preload the counter to all-ones via capture count -> the next capture wraps it to 0.
